warp_scheduler: RTL and testbench

WARP_SCHEDULER -- requirements
Module: warp_scheduler

---
 rtl/warp_scheduler.sv | 122 ++++++++++++
 tb/tb_warp_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/warp_scheduler.sv
// warp_scheduler: round-robin issue arbiter for the warps of one core
module warp_scheduler #(
    parameter int WARPS_PER_CORE = 2,
    localparam int WIDX = (WARPS_PER_CORE > 2) ? $clog2(WARPS_PER_CORE) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WIDX:0]             num_warps,
    input  logic [WARPS_PER_CORE-1:0] warp_ready,
    input  logic [WARPS_PER_CORE-1:0] warp_retire,
    input  logic                      issue_ready,
    output logic                      issue_valid,
    output logic [WIDX-1:0]           issue_warp,
    output logic [WARPS_PER_CORE-1:0] warp_grant,
    output logic [WARPS_PER_CORE-1:0] warp_active,
    output logic [15:0]               issue_count,
    output logic                      done
);
    localparam logic [WIDX:0] WCOUNT = (WIDX+1)'(WARPS_PER_CORE);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t                    state, state_next;
    logic                      run, launch, accept, load, found;
    logic [WARPS_PER_CORE-1:0] eligible, pick_mask, active_next;
    logic [WIDX-1:0]           rr_ptr, base, sel, warp_inc;
    logic [WIDX:0]             inc_sum, idx_sum, cand;

    // state register
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_next;
    end

    // next state: launch on start, finish once every launched warp has retired
    always_comb begin
        state_next = state;
        if (state == IDLE && start)
            state_next = RUN;
        else if (state == RUN && warp_active == '0)
            state_next = DONE;
    end

    // state-decoded controls
    always_comb begin
        run    = (state == RUN);
        launch = (state == IDLE) && start;
    end

    // acceptance handshake and one-hot grant of the offered warp
    always_comb begin
        accept = issue_valid && issue_ready;
        warp_grant = '0;
        warp_grant[issue_warp] = accept;
    end

    // eligibility; the warp being accepted is masked so it cannot issue twice in a row
    always_comb begin
        eligible  = warp_active & warp_ready & ~warp_retire;
        pick_mask = accept ? (eligible & ~warp_grant) : eligible;
        inc_sum   = {1'b0, issue_warp} + (WIDX+1)'(1);
        warp_inc  = (inc_sum == WCOUNT) ? '0 : inc_sum[WIDX-1:0];
        base      = accept ? warp_inc : rr_ptr;
        load      = !issue_valid || issue_ready || warp_retire[issue_warp];
    end

    // round-robin search from base upward, wrapping at WARPS_PER_CORE
    always_comb begin
        found   = 1'b0;
        sel     = '0;
        idx_sum = '0;
        cand    = '0;
        for (int i = 0; i < WARPS_PER_CORE; i++) begin
            idx_sum = {1'b0, base} + (WIDX+1)'(i);
            cand    = (idx_sum >= WCOUNT) ? idx_sum - WCOUNT : idx_sum;
            if (!found && pick_mask[cand[WIDX-1:0]]) begin
                found = 1'b1;
                sel   = cand[WIDX-1:0];
            end
        end
    end

    // active mask: loaded on launch (clamped to the core size), cleared by retire
    always_comb begin
        active_next = warp_active;
        if (launch) begin
            for (int k = 0; k < WARPS_PER_CORE; k++)
                active_next[k] = num_warps > (WIDX+1)'(k);
        end else if (run) begin
            active_next = warp_active & ~warp_retire;
        end
    end

    // registered offer, round-robin pointer, issue counter and done flag
    always_ff @(posedge clk) begin
        if (reset) begin
            warp_active <= '0;
            rr_ptr      <= '0;
            issue_count <= '0;
            issue_valid <= 1'b0;
            issue_warp  <= '0;
            done        <= 1'b0;
        end else begin
            warp_active <= active_next;
            done        <= (state_next == DONE);
            if (launch) begin
                rr_ptr      <= '0;
                issue_count <= '0;
            end else if (accept) begin
                rr_ptr <= warp_inc;
                if (issue_count != 16'hFFFF)
                    issue_count <= issue_count + 16'd1;
            end
            if (!run || state_next != RUN) begin
                issue_valid <= 1'b0;
            end else if (load) begin
                issue_valid <= found;
                issue_warp  <= sel;
            end
        end
    end
endmodule

// File: tb/tb_warp_scheduler.sv
// tb_warp_scheduler: directed scoreboard bench for two-warp and four-warp schedulers
module tb_warp_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        st2, ir2, iv2, dn2;
    logic [1:0]  nw2, rdy2, ret2, gr2, act2;
    logic [0:0]  iw2;
    logic [15:0] cnt2;
    logic        st4, ir4, iv4, dn4;
    logic [2:0]  nw4;
    logic [3:0]  rdy4, ret4, gr4, act4;
    logic [1:0]  iw4;
    logic [15:0] cnt4;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int seen;

    always #5 clk = ~clk;

    warp_scheduler #(.WARPS_PER_CORE(2)) dut2 (
        .clk(clk), .reset(reset), .start(st2), .num_warps(nw2), .warp_ready(rdy2),
        .warp_retire(ret2), .issue_ready(ir2), .issue_valid(iv2), .issue_warp(iw2),
        .warp_grant(gr2), .warp_active(act2), .issue_count(cnt2), .done(dn2)
    );

    warp_scheduler #(.WARPS_PER_CORE(4)) dut4 (
        .clk(clk), .reset(reset), .start(st4), .num_warps(nw4), .warp_ready(rdy4),
        .warp_retire(ret4), .issue_ready(ir4), .issue_valid(iv4), .issue_warp(iw4),
        .warp_grant(gr4), .warp_active(act4), .issue_count(cnt4), .done(dn4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pop one expected warp per accepted issue until the queue empties or the budget runs out
    task automatic drain(input bit four, input string tag);
        int budget = 0;
        int e;
        while (exp_q.size() > 0 && budget < 40) begin
            tick();
            #1;
            budget++;
            if (four ? (iv4 && ir4) : (iv2 && ir2)) begin
                e = exp_q.pop_front();
                chk({tag, "_warp"}, four ? 32'(iw4) : 32'(iw2), e);
                chk({tag, "_grant"}, four ? 32'(gr4) : 32'(gr2), 32'(1) << e);
            end
        end
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        {st2, ir2, nw2, rdy2, ret2} = '0;
        {st4, ir4, nw4, rdy4, ret4} = '0;
        tick();
        tick();
        #1;
        chk("rst_valid", {iv2, iv4}, 0);
        chk("rst_warp", {iw2, iw4}, 0);
        chk("rst_active", {act2, act4}, 0);
        chk("rst_count", {cnt2, cnt4}, 0);
        chk("rst_done", {dn2, dn4}, 0);
        reset = 1'b0;

        // two warps, both ready, pipeline always accepting: strict alternation
        tick();
        st2 = 1'b1; nw2 = 2'd2; rdy2 = 2'b11; ir2 = 1'b1;
        tick();
        st2 = 1'b0;
        #1;
        chk("a_first_valid", iv2, 0);
        chk("a_active", act2, 2'b11);
        exp_q = '{0, 1, 0, 1, 0, 1};
        drain(1'b0, "a");
        tick();
        ir2 = 1'b0;
        #1;
        chk("a_count", cnt2, 6);
        chk("a_next_offer", {iv2, iw2}, 2'b10);
        ret2 = 2'b11;
        tick();
        ret2 = 2'b00;
        #1;
        chk("a_retired", act2, 0);
        chk("a_withdrawn", iv2, 0);
        tick();
        #1;
        chk("a_done", {dn2, iv2}, 2'b10);
        st2 = 1'b1;
        tick();
        st2 = 1'b0;
        #1;
        chk("a_start_in_done", {dn2, act2}, 3'b100);

        // one warp launched on a two-warp core: only warp 0 ever offered
        reset = 1'b1;
        tick();
        reset = 1'b0;
        st2 = 1'b1; nw2 = 2'd1; rdy2 = 2'b11; ir2 = 1'b1;
        tick();
        st2 = 1'b0;
        #1;
        chk("b_active", act2, 2'b01);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            #1;
            seen += int'(iv2);
            chk("b_only_w0", iv2 ? 32'(iw2) : 32'd0, 0);
        end
        chk("b_offered", seen > 0, 1);
        ret2 = 2'b01;
        tick();
        ret2 = 2'b00;
        #1;
        chk("b_done_early", {dn2, act2}, 0);
        tick();
        #1;
        chk("b_done", dn2, 1);

        // four warps, stall holds the offer, acceptance moves to the next eligible warp
        st4 = 1'b1; nw4 = 3'd4; rdy4 = 4'b1010; ir4 = 1'b0;
        tick();
        st4 = 1'b0;
        #1;
        chk("c_first_valid", iv4, 0);
        tick();
        #1;
        chk("c_hold1", {iv4, iw4}, 3'b101);
        rdy4 = 4'b1000;
        tick();
        #1;
        chk("c_hold2", {iv4, iw4, gr4}, 7'b1010000);
        rdy4 = 4'b1010;
        tick();
        #1;
        chk("c_hold3", {iv4, iw4}, 3'b101);
        ir4 = 1'b1;
        #1;
        chk("c_grant", gr4, 4'b0010);
        tick();
        ir4 = 1'b0;
        ret4 = 4'b1000;
        #1;
        chk("c_next_offer", {iv4, iw4}, 3'b111);
        chk("c_count", cnt4, 1);
        tick();
        ret4 = 4'b0000;
        #1;
        chk("d_reselect", {iv4, iw4}, 3'b101);
        chk("d_active", act4, 4'b0111);

        // reset mid-run drops everything, then a clamped relaunch
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("d_rst_state", {iv4, iw4, act4, gr4, dn4}, 0);
        chk("d_rst_count", cnt4, 0);
        st4 = 1'b1; nw4 = 3'd7; rdy4 = 4'b1111; ir4 = 1'b1;
        tick();
        st4 = 1'b0;
        #1;
        chk("d_clamp", act4, 4'b1111);
        exp_q = '{0, 1, 2, 3, 0};
        drain(1'b1, "d");
        tick();
        ir4 = 1'b0;
        #1;
        chk("d_count", cnt4, 5);

        // zero warps: straight to done without ever offering
        reset = 1'b1;
        tick();
        reset = 1'b0;
        st4 = 1'b1; nw4 = 3'd0; ir4 = 1'b1;
        tick();
        st4 = 1'b0;
        #1;
        chk("e_run_empty", {act4, iv4, dn4}, 0);
        tick();
        #1;
        chk("e_done", {dn4, iv4}, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
